// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame transmitter.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;

  // Clock cycles from the first START cycle through the last STOP cycle.
  function automatic int unsigned frame_len(input int unsigned width, input int unsigned bit_cycles);
    return (width + 32'd2) * bit_cycles;
  endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 and flags the terminal count.
module bit_timer
  import serial_frame_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic clr_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(BIT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  // Next count: hold at zero while restarted, wrap on the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB-first, stop bit,
// each held BIT_CYCLES clocks. Line and busy are registered.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             abort,
  output logic             Dout,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             run_q, run_d;
  logic             accept;
  logic             restart;
  logic             tick;

  // run_q keeps tx_ready low until the first edge after reset release.
  assign tx_ready = run_q & (state_q == IDLE) & ~abort;
  assign accept   = tx_valid & tx_ready;
  assign restart  = abort | (state_q == IDLE);
  assign Dout     = dout_q;
  assign busy     = busy_q;

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk    (clk),
    .clr_n  (clr_n),
    .restart(restart),
    .tick   (tick)
  );

  // Frame sequencing, shifting and registered line/busy decode from next state.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    run_d     = 1'b1;
    if (abort) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d   = START;
            shift_d   = tx_data;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
        START: begin
          if (tick) begin
            state_d = DATA;
          end else begin
            state_d = START;
          end
        end
        DATA: begin
          if (tick) begin
            shift_d   = shift_q >> 1'b1;
            bit_cnt_d = bit_cnt_q + BW'(1);
            if (bit_cnt_q == BIT_LAST) begin
              state_d = STOP;
            end else begin
              state_d = DATA;
            end
          end else begin
            state_d = DATA;
          end
        end
        STOP: begin
          if (tick) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else begin
            state_d = STOP;
          end
        end
        default: begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end
      endcase
    end

    case (state_d)
      IDLE:    dout_d = LINE_IDLE;
      START:   dout_d = 1'b0;
      DATA:    dout_d = shift_d[0];
      STOP:    dout_d = LINE_IDLE;
      default: dout_d = LINE_IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      dout_q    <= LINE_IDLE;
      busy_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      run_q     <= run_d;
    end
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter: accepts a parallel word over a valid/ready handshake and drives it onto a single-bit serial line as a framed bit stream (start bit, data LSB-first, stop bit). Each bit is held for a programmable number of clock cycles. Sits upstream of the priority D flip-flop capture stage: its `Dout` line is what that stage samples as `Din`.

## Interface
- `WIDTH`, default 8: data bits per frame; must be ≥ 1.
- `BIT_CYCLES`, default 4: clock cycles each serial bit is held; must be ≥ 1.

- `clk`  in  1  single clock; all state updates on rising edge.
- `clr_n`  in  1  asynchronous, active-low reset.
- `tx_data`  in  WIDTH  word to send; sampled only on acceptance.
- `tx_valid`  in  1  producer has a word.
- `tx_ready`  out  1  block can accept; combinational, high only in IDLE with `abort` low.
- `abort`  in  1  synchronous frame cancel.
- `Dout`  out  1  serial line, registered; idle level 1.
- `busy`  out  1  registered; high in any state other than IDLE.

## Operation
- States:
  - IDLE: `Dout`=1.
  - START: `Dout`=0.
  - DATA: `Dout`=current shift-register LSB.
  - STOP: `Dout`=1.
- Acceptance: on a rising edge with `tx_valid & tx_ready`, the word is latched into the shift register, the bit counter and cycle counter are cleared, and the state moves to START.
- Bit timing: the cycle counter runs 0..BIT_CYCLES-1. A bit tick occurs when the counter reaches BIT_CYCLES-1; at a tick the counter wraps to 0.
- Transitions on a bit tick:
  - START → DATA.
  - DATA: shift right by one and increment the bit counter. After bit WIDTH-1, go to STOP.
  - STOP → IDLE.
- Frame length: (WIDTH+2)·BIT_CYCLES cycles, from the first START cycle through the last STOP cycle.
- Back-to-back frames: `tx_ready` rises in the IDLE cycle after STOP. The minimum gap between frames is one idle cycle with `Dout`=1.
- `tx_data` changes after acceptance do not affect the frame in flight.
- `abort` high on any edge: the state goes to IDLE, counters clear, and `Dout`=1 from the next cycle. In IDLE, `abort` masks `tx_ready`, so no word is accepted.
- `abort` and `tx_valid` high in the same cycle: abort wins and the word is not taken.
- Reset (`clr_n` low, any time, including mid-frame): state=IDLE, `Dout`=1, `busy`=0, counters=0, shift register=0. `tx_ready`=0 while reset is held, and rises to 1 in the first cycle after release if `abort` is low.
- Counter widths: bit counter is $clog2(WIDTH)+1 bits; cycle counter is $clog2(BIT_CYCLES)+1 bits. No wrap beyond the terminal values.

## Timing
- Acceptance edge at T: `Dout`=0 and `busy`=1 from T+1.
- Data bit k is driven on cycles T+1+(k+1)·BIT_CYCLES through T+(k+2)·BIT_CYCLES.
- STOP ends at T+(WIDTH+2)·BIT_CYCLES. `busy`=0 and `tx_ready`=1 from the next cycle.
- BIT_CYCLES=1: one cycle per bit, same state sequence.

## Structure
- Package `serial_frame_pkg`:
  - state enum: IDLE, START, DATA, STOP.
  - function `frame_len(WIDTH, BIT_CYCLES)`.
  - constant `LINE_IDLE = 1'b1`.
- Sub-module `bit_timer`:
  - parameter BIT_CYCLES.
  - inputs `clk`, `clr_n`, `restart`.
  - output `tick`, one cycle wide on the terminal count.
- The top level holds the FSM, shift register and bit counter.

## Test plan
- WIDTH=8, BIT_CYCLES=4, send 0xA5 → `Dout` per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1. Total 40 cycles; `busy` high exactly 40 cycles.
- Two words 0x00 then 0xFF with `tx_valid` held high → second START begins exactly 1 idle cycle after the first STOP; `tx_ready` pulses once between frames.
- `clr_n` low during DATA bit 3 → `Dout`=1 and `busy`=0 the same cycle. After release, a new 0x3C frame is sent correctly.
- `abort` during STOP of 0x81 → IDLE next cycle, `Dout`=1. `abort`+`tx_valid` together in IDLE → no frame, `busy` stays 0.
- Change `tx_data` every cycle after accepting 0x5A → serial bits still encode 0x5A.
- WIDTH=4, BIT_CYCLES=1, send 0x9 → `Dout`=0,1,0,0,1,1 on 6 consecutive cycles.
